// File: rtl/alarm_beeper.sv
`default_nettype none
// ============================================================================
// Module   : alarm_beeper
// Brief    : Turns the synchronised 'alarming' level into a patterned piezo
//            tone: BEEPS beeps separated by gaps, then a longer pause, repeat.
//            Also drives a beep LED and the current beep index.
// Revision : 1.0  initial release
// ============================================================================
module alarm_beeper #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int TONE_HZ  = 2000,
   parameter int BEEP_MS  = 200,
   parameter int GAP_MS   = 200,
   parameter int PAUSE_MS = 800,
   parameter int BEEPS    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       alarming,
   input  logic       mute,
   output logic       buzzer,
   output logic       beeping,
   output logic [2:0] beep_idx
);

   localparam int c_HALF   = CLK_HZ / (2 * TONE_HZ);
   localparam int c_MS     = CLK_HZ / 1000;
   localparam int c_MAX_MS = (BEEP_MS > GAP_MS)
                           ? ((BEEP_MS > PAUSE_MS) ? BEEP_MS : PAUSE_MS)
                           : ((GAP_MS  > PAUSE_MS) ? GAP_MS  : PAUSE_MS);
   localparam int c_PW     = $clog2(c_MS) + 1;
   localparam int c_TW     = $clog2(c_MAX_MS) + 1;
   localparam int c_HW     = $clog2(c_HALF) + 1;

   localparam logic [c_PW-1:0] c_MS_LAST    = c_PW'(c_MS - 1);
   localparam logic [c_HW-1:0] c_HALF_LAST  = c_HW'(c_HALF - 1);
   localparam logic [c_TW-1:0] c_BEEP_LAST  = c_TW'(BEEP_MS - 1);
   localparam logic [c_TW-1:0] c_GAP_LAST   = c_TW'(GAP_MS - 1);
   localparam logic [c_TW-1:0] c_PAUSE_LAST = c_TW'(PAUSE_MS - 1);
   localparam logic [2:0]      c_BEEPS      = 3'(BEEPS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEEP  = 2'd1,
      S_GAP   = 2'd2,
      S_PAUSE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [2:0]        w_idx_next;
   logic              w_enter;
   logic              w_tick;
   logic              r_sync1;
   logic              r_req;
   logic [c_PW-1:0]   r_pre;
   logic [c_TW-1:0]   r_timer;
   logic [c_HW-1:0]   r_tone;
   logic              r_raw;

   assign w_tick  = (r_pre == c_MS_LAST);
   assign w_enter = (w_next != r_state);

   // Two-flop synchroniser bringing the alarm level into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_req   <= 1'b0;
      end else begin
         r_sync1 <= alarming;
         r_req   <= r_sync1;
      end
   end

   // Next-state and beep index; a dropped request overrides any timer expiry
   always_comb begin
      w_next     = r_state;
      w_idx_next = beep_idx;
      if (!r_req) begin
         w_next     = S_IDLE;
         w_idx_next = 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_next     = S_BEEP;
               w_idx_next = 3'd1;
            end
            S_BEEP: begin
               if (w_tick && (r_timer == c_BEEP_LAST))
                  w_next = (beep_idx < c_BEEPS) ? S_GAP : S_PAUSE;
            end
            S_GAP: begin
               if (w_tick && (r_timer == c_GAP_LAST)) begin
                  w_next     = S_BEEP;
                  w_idx_next = beep_idx + 3'd1;
               end
            end
            S_PAUSE: begin
               if (w_tick && (r_timer == c_PAUSE_LAST)) begin
                  w_next     = S_BEEP;
                  w_idx_next = 3'd1;
               end
            end
            default: begin
               w_next     = S_IDLE;
               w_idx_next = 3'd0;
            end
         endcase
      end
   end

   // State register; LED and index update on the same edge as the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         beeping  <= 1'b0;
         beep_idx <= 3'd0;
      end else begin
         r_state  <= w_next;
         beeping  <= (w_next == S_BEEP);
         beep_idx <= w_idx_next;
      end
   end

   // Millisecond prescaler and state timer, restarted on every state entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre   <= '0;
         r_timer <= '0;
      end else if (w_enter || (r_state == S_IDLE)) begin
         r_pre   <= '0;
         r_timer <= '0;
      end else begin
         r_pre   <= w_tick ? '0 : (r_pre + c_PW'(1));
         r_timer <= w_tick ? (r_timer + c_TW'(1)) : r_timer;
      end
   end

   // Tone generator: fresh low phase at each BEEP entry, silent elsewhere
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tone <= '0;
         r_raw  <= 1'b0;
      end else if ((w_next != S_BEEP) || (r_state != S_BEEP)) begin
         r_tone <= '0;
         r_raw  <= 1'b0;
      end else if (r_tone == c_HALF_LAST) begin
         r_tone <= '0;
         r_raw  <= ~r_raw;
      end else begin
         r_tone <= r_tone + c_HW'(1);
      end
   end

   // Registered, mutable buzzer drive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) buzzer <= 1'b0;
      else        buzzer <= r_raw & ~mute;
   end

endmodule
`default_nettype wire

// File: tb/tb_alarm_beeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_beeper
// Brief    : Scoreboard bench for alarm_beeper. Stimulus queues the expected
//            output segments (LED/index run, length, tone-high count and
//            first tone-high offset); a monitor closes each observed segment
//            and compares it against the queue head.
// Revision : 1.0  initial release
// ============================================================================
module tb_alarm_beeper;

   typedef struct {
      logic       b;
      logic [2:0] idx;
      int         len;
      int         highs;
      int         first;
   } seg_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       alarming = 1'b0;
   logic       alarming1 = 1'b0;
   logic       mute = 1'b0;
   logic       buzzer0, beeping0, buzzer1, beeping1;
   logic [2:0] idx0, idx1;
   logic       sel = 1'b0;
   logic       mon_en = 1'b0;

   logic       m_buzzer, m_beeping;
   logic [2:0] m_idx;

   seg_t       sb_q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   int         starts = 0;
   logic       prev_b = 1'b0;

   logic [3:0] cur_key = 4'd0;
   int         seg_len = 0;
   int         seg_highs = 0;
   int         seg_first = -1;

   always #5 clk = ~clk;

   alarm_beeper #(.CLK_HZ(8000), .TONE_HZ(1000), .BEEP_MS(2), .GAP_MS(1),
                  .PAUSE_MS(3), .BEEPS(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .alarming(alarming), .mute(mute),
      .buzzer(buzzer0), .beeping(beeping0), .beep_idx(idx0));

   alarm_beeper #(.CLK_HZ(8000), .TONE_HZ(1000), .BEEP_MS(2), .GAP_MS(1),
                  .PAUSE_MS(3), .BEEPS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .alarming(alarming1), .mute(mute),
      .buzzer(buzzer1), .beeping(beeping1), .beep_idx(idx1));

   assign m_buzzer  = sel ? buzzer1  : buzzer0;
   assign m_beeping = sel ? beeping1 : beeping0;
   assign m_idx     = sel ? idx1     : idx0;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic push(input logic b, input logic [2:0] idx, input int len,
                       input int highs, input int first);
      seg_t s;
      s.b = b; s.idx = idx; s.len = len; s.highs = highs; s.first = first;
      sb_q.push_back(s);
   endtask

   // full beep: tone high on offsets 4..7 and 12..15 (as seen one cycle later)
   task automatic push_beep(input logic [2:0] idx);
      push(1'b1, idx, 16, 8, 4);
   endtask

   task automatic wait_entry(input logic b, input logic [2:0] idx, input int nth, input int maxc);
      int         seen;
      int         c;
      logic [3:0] prev;
      seen = 0;
      c    = 0;
      prev = {m_beeping, m_idx};
      while (seen < nth && c < maxc) begin
         @(negedge clk);
         c++;
         if ({m_beeping, m_idx} == {b, idx} && prev != {b, idx}) seen++;
         prev = {m_beeping, m_idx};
      end
      if (seen < nth) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_entry b=%0d idx=%0d: saw %0d of %0d entries", b, idx, seen, nth);
      end
   endtask

   task automatic check_idle(input string name);
      check({name, " buzzer"}, int'(m_buzzer), 0);
      check({name, " beeping"}, int'(m_beeping), 0);
      check({name, " beep_idx"}, int'(m_idx), 0);
   endtask

   // Beep-start counter used for the pulse sweep
   always @(negedge clk) begin
      if (m_beeping && !prev_b) starts++;
      prev_b = m_beeping;
   end

   // Monitor: buzzer is one register behind the tone, so each buzzer sample
   // is credited to the segment that was current one sample earlier
   always @(negedge clk) begin
      logic [3:0] key;
      seg_t       e;
      key = {m_beeping, m_idx};
      if (!mon_en) begin
         cur_key   = 4'd0;
         seg_len   = 0;
         seg_highs = 0;
         seg_first = -1;
      end else begin
         if (m_buzzer && seg_len > 0) begin
            if (seg_highs == 0) seg_first = seg_len - 1;
            seg_highs++;
         end
         if (key != cur_key) begin
            if (cur_key != 4'd0) begin
               n_vec++;
               if (sb_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL seg unexpected: b=%0d idx=%0d len=%0d highs=%0d first=%0d",
                           cur_key[3], cur_key[2:0], seg_len, seg_highs, seg_first);
               end else begin
                  e = sb_q.pop_front();
                  if (e.b != cur_key[3] || e.idx != cur_key[2:0] || e.len != seg_len ||
                      e.highs != seg_highs || e.first != seg_first) begin
                     n_bad++;
                     $display("FAIL seg: got b=%0d idx=%0d len=%0d highs=%0d first=%0d, expected b=%0d idx=%0d len=%0d highs=%0d first=%0d",
                              cur_key[3], cur_key[2:0], seg_len, seg_highs, seg_first,
                              e.b, e.idx, e.len, e.highs, e.first);
                  end
               end
            end
            cur_key   = key;
            seg_len   = 0;
            seg_highs = 0;
            seg_first = -1;
         end
         seg_len++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int c;

      // ---- reset state
      #1 rst_n = 1'b0;
      #1 check_idle("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ---- asynchronous reset mid-beep with the buzzer high
      alarming = 1'b1;
      wait_entry(1'b1, 3'd1, 1, 20);
      c = 0;
      while (!m_buzzer && c < 20) begin
         @(negedge clk);
         c++;
      end
      check("pre-reset buzzer", int'(m_buzzer), 1);
      #2 rst_n = 1'b0;
      #1 check_idle("async reset");
      alarming = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(negedge clk);
      mon_en = 1'b1;

      // ---- three full groups, then drop during the fourth gap (offset 3)
      for (int g = 0; g < 3; g++) begin
         push_beep(3'd1);
         push(1'b0, 3'd1, 8, 0, -1);
         push_beep(3'd2);
         push(1'b0, 3'd2, 24, 0, -1);
      end
      push_beep(3'd1);
      push(1'b0, 3'd1, 6, 0, -1);
      alarming = 1'b1;
      @(posedge clk); #1 check("beeping after 1 edge", int'(m_beeping), 0);
      @(posedge clk); @(posedge clk);
      #1 check("beeping after 3 edges", int'(m_beeping), 1);
      check("beep_idx at start", int'(m_idx), 1);
      wait_entry(1'b0, 3'd1, 4, 400);
      repeat (3) @(negedge clk);
      alarming = 1'b0;
      repeat (6) @(negedge clk);
      check_idle("after gap drop");

      // ---- drop during a beep (offset 5); re-raise starts a fresh phase
      push(1'b1, 3'd1, 8, 4, 4);
      alarming = 1'b1;
      wait_entry(1'b1, 3'd1, 1, 20);
      repeat (5) @(negedge clk);
      alarming = 1'b0;
      repeat (6) @(negedge clk);
      check_idle("after beep drop");

      // ---- mute: first half of beep 1, all of beep 2
      push(1'b1, 3'd1, 16, 4, 12);
      push(1'b0, 3'd1, 8, 0, -1);
      push(1'b1, 3'd2, 16, 0, -1);
      push(1'b0, 3'd2, 24, 0, -1);
      push_beep(3'd1);
      push(1'b0, 3'd1, 6, 0, -1);
      alarming = 1'b1;
      wait_entry(1'b1, 3'd1, 1, 20);
      mute = 1'b1;
      repeat (8) @(negedge clk);
      mute = 1'b0;
      wait_entry(1'b1, 3'd2, 1, 60);
      mute = 1'b1;
      wait_entry(1'b0, 3'd2, 1, 60);
      mute = 1'b0;
      wait_entry(1'b0, 3'd1, 1, 80);
      repeat (3) @(negedge clk);
      alarming = 1'b0;
      repeat (8) @(negedge clk);

      // ---- pulse sweep across the clock phase: 1-cycle and 2-cycle pulses
      mon_en = 1'b0;
      for (int w = 1; w <= 2; w++) begin
         for (int off = 1; off <= 9; off++) begin
            s0 = starts;
            @(posedge clk);
            #(off) alarming = 1'b1;
            #(w * 10) alarming = 1'b0;
            repeat (8) @(negedge clk);
            if (w == 2) check($sformatf("2cyc pulse off=%0d starts", off), starts - s0, 1);
            else        check($sformatf("1cyc pulse off=%0d at most one start", off),
                              int'((starts - s0) <= 1), 1);
         end
      end

      // ---- single-beep groups: beep then pause, never a gap
      sel = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      for (int g = 0; g < 3; g++) begin
         push_beep(3'd1);
         push(1'b0, 3'd1, 24, 0, -1);
      end
      push_beep(3'd1);
      push(1'b0, 3'd1, 6, 0, -1);
      alarming1 = 1'b1;
      wait_entry(1'b0, 3'd1, 4, 400);
      repeat (3) @(negedge clk);
      alarming1 = 1'b0;
      repeat (6) @(negedge clk);
      check_idle("single-beep idle");

      // ---- every queued segment must have been observed
      c = 0;
      while (sb_q.size() != 0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("segments left in queue", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
